// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for the two-source round-robin arbiter.
// Carries both valid/ready sources, the mux select and the registered
// output beat.
//   master : the side that drives the sources and the downstream ready
//   slave  : the arbiter itself
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             vld0;
  logic [WIDTH-1:0] dat0;
  logic             rdy0;
  logic             vld1;
  logic [WIDTH-1:0] dat1;
  logic             rdy1;
  logic             sel;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             out_rdy;

  modport master (
    output vld0, dat0, vld1, dat1, out_rdy,
    input  rdy0, rdy1, sel, out_vld, out_dat
  );

  modport slave (
    input  vld0, dat0, vld1, dat1, out_rdy,
    output rdy0, rdy1, sel, out_vld, out_dat
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-channel round-robin arbiter feeding a 2:1 select mux, with a single
// registered output stage. A per-grant burst counter hands the grant over
// after MAX_BURST accepted beats whenever the other source is waiting.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux2_rr_arbiter_if (vld0/dat0/rdy0, vld1/dat1/rdy1,
//           sel, out_vld/out_dat/out_rdy). Interface WIDTH must match WIDTH.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux2_rr_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             sel_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_dat_q;

  logic   space;
  logic   rdy0;
  logic   rdy1;
  logic   acc0;
  logic   acc1;
  logic   cur_id;
  logic   cur_vld;
  logic   oth_vld;
  logic   cur_acc;
  state_t other_grant;

  // The output register can take a new beat if it is empty or being drained
  // this cycle, so a held grant streams one beat per cycle.
  always_comb begin
    space       = !out_vld_q || bus.out_rdy;
    rdy0        = (state == GRANT0) && space;
    rdy1        = (state == GRANT1) && space;
    acc0        = bus.vld0 && rdy0;
    acc1        = bus.vld1 && rdy1;
    cur_id      = (state == GRANT1);
    cur_vld     = cur_id ? bus.vld1 : bus.vld0;
    oth_vld     = cur_id ? bus.vld0 : bus.vld1;
    cur_acc     = acc0 || acc1;
    other_grant = cur_id ? GRANT0 : GRANT1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      sel_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      // Output stage: load on accept, drain when downstream takes it,
      // otherwise hold beat and data.
      if (acc0) begin
        out_vld_q <= 1'b1;
        out_dat_q <= bus.dat0;
      end else if (acc1) begin
        out_vld_q <= 1'b1;
        out_dat_q <= bus.dat1;
      end else if (bus.out_rdy) begin
        out_vld_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          // On a tie the source that did not hold the last grant wins;
          // last resets to 1 so source 0 wins the first tie.
          if (bus.vld0 && (!bus.vld1 || last)) begin
            state <= GRANT0;
            sel_q <= 1'b0;
          end else if (bus.vld1) begin
            state <= GRANT1;
            sel_q <= 1'b1;
          end
        end

        GRANT0, GRANT1: begin
          if (cur_acc && (cnt == CNT_LAST)) begin
            // Burst limit reached: hand over if the other side waits,
            // otherwise keep the grant and start a fresh burst.
            cnt <= '0;
            if (oth_vld) begin
              state <= other_grant;
              sel_q <= !cur_id;
              last  <= cur_id;
            end
          end else if (!cur_vld) begin
            // Holder released its request.
            cnt  <= '0;
            last <= cur_id;
            if (oth_vld) begin
              state <= other_grant;
              sel_q <= !cur_id;
            end else begin
              state <= IDLE;
              sel_q <= 1'b0;
            end
          end else if (cur_acc) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          sel_q <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rdy0    = rdy0;
  assign bus.rdy1    = rdy1;
  assign bus.sel     = sel_q;
  assign bus.out_vld = out_vld_q;
  assign bus.out_dat = out_dat_q;

endmodule
